// File: rtl/slicer_error_power_pkg.sv
// slicer_error_power_pkg: shared data width, error limit and 4-ASK symbol codes
package slicer_error_power_pkg;
    localparam int DW = 18;
    localparam int ERR_MAX = 131071;
    localparam logic [1:0] SYM_M3 = 2'b00;
    localparam logic [1:0] SYM_M1 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b10;
    localparam logic [1:0] SYM_P3 = 2'b11;
endpackage

// File: rtl/ask4_slicer.sv
// ask4_slicer: 4-ASK threshold slicer with ideal-level reconstruction and saturating error
module ask4_slicer
    import slicer_error_power_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic [DW-1:0] decision_var,
    input  logic [DW-1:0] ref_level,
    output logic [1:0]    symbol,
    output logic [DW-1:0] slicer_error,
    output logic          sym_valid
);
    localparam logic signed [DW+1:0] EMAX = (DW+2)'(ERR_MAX);
    localparam logic signed [DW+1:0] EMIN = -EMAX;
    // 20 bits covers +-1.5*ref and the raw difference before saturation
    logic signed [DW+1:0] dv, r, b, b3, recon, err;
    logic [1:0] sym_n;
    logic [DW-1:0] sat;
    always_comb begin
        dv = {{2{decision_var[DW-1]}}, decision_var};
        r = ref_level[DW-1] ? '0 : {2'b00, ref_level};
        b = r >>> 1;
        b3 = r + b;
        sym_n = dv < -r ? SYM_M3 : dv[DW+1] ? SYM_M1 : dv < r ? SYM_P1 : SYM_P3;
        recon = sym_n == SYM_M3 ? -b3 : sym_n == SYM_M1 ? -b : sym_n == SYM_P1 ? b : b3;
        err = dv - recon;
        sat = err > EMAX ? EMAX[DW-1:0] : err < EMIN ? EMIN[DW-1:0] : err[DW-1:0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            symbol <= SYM_M3;
            slicer_error <= '0;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= clk_en;
            if (clk_en) begin
                symbol <= sym_n;
                slicer_error <= sat;
            end
        end
    end
endmodule

// File: rtl/slicer_error_power.sv
// slicer_error_power: 4-ASK slicer followed by windowed mean-squared-error estimator
module slicer_error_power
    import slicer_error_power_pkg::*;
#(
    parameter int LOG2_N = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          clear_accum,
    input  logic [DW-1:0] decision_var,
    input  logic [DW-1:0] ref_level,
    output logic [1:0]    symbol,
    output logic [DW-1:0] slicer_error,
    output logic          sym_valid,
    output logic [DW-1:0] error_power,
    output logic          power_valid,
    output logic [15:0]   window_count
);
    localparam int ACC_W = 36 + LOG2_N;
    logic signed [35:0] err_ext;
    logic [35:0] sq;
    logic sq_valid;
    logic [ACC_W-1:0] acc, sq_ext;
    logic [15:0] count;
    ask4_slicer u_slicer (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .decision_var(decision_var),
        .ref_level(ref_level),
        .symbol(symbol),
        .slicer_error(slicer_error),
        .sym_valid(sym_valid)
    );
    assign err_ext = {{18{slicer_error[DW-1]}}, slicer_error};
    assign sq_ext = ACC_W'(sq);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq <= '0;
            sq_valid <= 1'b0;
        end else begin
            sq_valid <= sym_valid;
            if (sym_valid) sq <= err_ext * err_ext;
        end
    end
    // a square landing on the clear cycle opens the new window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            count <= '0;
            error_power <= '0;
            window_count <= '0;
            power_valid <= 1'b0;
        end else begin
            power_valid <= clear_accum;
            if (clear_accum) begin
                error_power <= acc[LOG2_N+33:LOG2_N+16];
                window_count <= count;
                acc <= sq_valid ? sq_ext : '0;
                count <= {15'd0, sq_valid};
            end else if (sq_valid) begin
                acc <= acc + sq_ext;
                count <= &count ? count : count + 16'd1;
            end
        end
    end
endmodule

// File: doc/slicer_error_power.md
Name: slicer_error_power

Overview:
- 4-ASK decision slicer and error-power estimator, directly downstream of mapper_power.
- Consumes the same decision_var stream plus mapper_power's ref_level (average |y| ≈ 2b).
- Slices each symbol against thresholds {-ref, 0, +ref}, reconstructs the ideal level {±b, ±3b}, and forms the slicer error.
- Averages squared error over a 2^LOG2_N-symbol window aligned to clear_accum; the result feeds MER computation alongside mapper_power.

Parameters:
LOG2_N, 20, log2 of nominal window length; accumulator mean = acc >> LOG2_N
ACC_W, 36+LOG2_N, accumulator width (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  symbol strobe; decision_var valid this cycle
clear_accum  in  1  window boundary strobe (same strobe mapper_power uses)
decision_var  in  18  signed 1s17 soft decision
ref_level  in  18  signed reference (≈2b); values <0 treated as 0
symbol  out  2  sliced symbol: 00=-3b, 01=-b, 10=+b, 11=+3b
slicer_error  out  18  signed error, symmetric-saturated to ±131071
sym_valid  out  1  one-cycle pulse with each new symbol/slicer_error
error_power  out  18  unsigned windowed mean squared error, mean[33:16]
power_valid  out  1  one-cycle pulse when error_power updates
window_count  out  16  symbols in last closed window, saturating at 65535

Behaviour:
- Reset (async): all registers 0; symbol=00, slicer_error=0, sym_valid=0, error_power=0, power_valid=0, window_count=0, accumulator=0.
- Stage S1, updates only when clk_en=1; sym_valid=registered clk_en:
  - r = max(ref_level, 0); b = r>>>1; b3 = r + (r>>>1).
  - Slicing: dv < -r → 00, recon -b3; -r ≤ dv < 0 → 01, recon -b; 0 ≤ dv < r → 10, recon +b; dv ≥ r → 11, recon +b3.
  - Error computed 19-bit (dv − recon), saturated to [-131071, +131071]; the -131072 code is never emitted.
  - r=0: dv<0 → 00, dv≥0 → 11, recon 0, error = dv (saturated).
- Stage S2: when S1 valid, sq = slicer_error², 36-bit unsigned (max < 2^34); sq_valid one cycle after sym_valid.
- Stage S3, accumulator:
  - Adds sq when sq_valid, i.e. 3 cycles after clk_en.
  - Symbol counter increments with each add.
- clear_accum cycle:
  - error_power <= (acc >> LOG2_N)[33:16], using acc before this cycle's add.
  - window_count <= min(count, 65535).
  - power_valid pulses on the next cycle.
  - acc <= (sq_valid ? sq : 0); count <= (sq_valid ? 1 : 0).
  - The coincident sample starts the new window. Samples still in S1/S2 belong to the new window.
- Back-to-back clear_accum: second window empty → error_power=0, window_count=0.
- Accumulator never wraps: ACC_W holds 2^LOG2_N worst-case squares. Windows longer than 2^LOG2_N are allowed; the mean then scales proportionally (no clamp). The count is saturating.
- ref_level is sampled combinationally at S1; changes take effect on the next clk_en.
- clk_en and clear_accum may coincide; S1 still processes that symbol.

Decomposition:
- Shared package: symbol encoding constants (SYM_M3, SYM_M1, SYM_P1, SYM_P3), ERR_MAX=131071, data width 18.
- One sub-module: ask4_slicer. It contains S1 only: threshold compare, reconstruction, saturating error, output registers with clk_en. The top level holds S2/S3, counter and window logic.

Test Plan:
- reset=1 mid-window with acc nonzero → all outputs 0 immediately (async); after release, first clear_accum gives error_power=0, window_count=0.
- ref=4000; dv=2100 → symbol=10, error=+100. dv=-7000 → 00, -1000. dv=5000 → 11, -1000. dv=-1500 → 01, +500. Each result 1 cycle after clk_en, with sym_valid pulse.
- ref=0, dv=-131072 → symbol=00, error=-131071 (saturation). ref=-500, dv=10 → behaves as ref=0: symbol=11, error=10.
- LOG2_N=2, ref=4000, four clk_en with dv=3024 (error=1024, sq=2^20), then clear_accum ≥3 cycles later → error_power=16, window_count=4, power_valid pulse 1 cycle later.
- clear_accum coincident with sq_valid (error=1024), then 3 more error=1024 symbols, then clear → error_power=16, window_count=4. Confirms the coincident sample counted in the new window.
- Two consecutive-cycle clear_accum pulses → second gives error_power=0, window_count=0, two power_valid pulses.
